// File: rtl/tow_match_ctrl.sv
// Tug-of-war match sequencer: gates play, clears rounds, holds a cool-down,
// tallies round wins and declares the match winner. Optional round timer: TOW_TIMEOUT_EN.
module tow_match_ctrl #(
  parameter int WINS_TO_MATCH  = 3,
  parameter int HOLD_CYCLES    = 8,
  parameter int CNT_W          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             win1,
  input  logic             win2,
  output logic             play_en,
  output logic             round_clr,
  output logic [CNT_W-1:0] games1,
  output logic [CNT_W-1:0] games2,
  output logic             match_over,
  output logic [1:0]       winner,
  output logic             timeout
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] games1_q, games1_d;
  logic [CNT_W-1:0] games2_q, games2_d;
  logic [1:0]       winner_q, winner_d;
  logic             play_en_q, play_en_d;
  logic             round_clr_q, round_clr_d;
  logic             match_over_q, match_over_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] games1_inc, games2_inc;

`ifdef TOW_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q, timer_d;
`endif

  assign games1_inc = games1_q + CNT_W'(1);
  assign games2_inc = games2_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    games1_d   = games1_q;
    games2_d   = games2_q;
    winner_d   = winner_q;
    timeout_d  = 1'b0;
`ifdef TOW_TIMEOUT_EN
    timer_d    = timer_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        // A fresh match always starts from a clean tally.
        if (start) begin
          state_d  = S_PLAY;
          games1_d = '0;
          games2_d = '0;
          winner_d = 2'b00;
`ifdef TOW_TIMEOUT_EN
          timer_d  = '0;
`endif
        end
      end
      S_PLAY: begin
`ifdef TOW_TIMEOUT_EN
        timer_d = timer_q + TW'(1);
`endif
        if (win1 && !win2) begin
          games1_d   = games1_inc;
          hold_cnt_d = '0;
          if (games1_inc == CNT_W'(WINS_TO_MATCH)) begin
            state_d  = S_DONE;
            winner_d = 2'b01;
          end else begin
            state_d  = S_HOLD;
          end
        end else if (win2 && !win1) begin
          games2_d   = games2_inc;
          hold_cnt_d = '0;
          if (games2_inc == CNT_W'(WINS_TO_MATCH)) begin
            state_d  = S_DONE;
            winner_d = 2'b10;
          end else begin
            state_d  = S_HOLD;
          end
        end else if (win1 && win2) begin
          state_d    = S_HOLD;
          hold_cnt_d = '0;
`ifdef TOW_TIMEOUT_EN
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // Expiry only counts when no win arrives on the same cycle.
          state_d    = S_HOLD;
          hold_cnt_d = '0;
          timeout_d  = 1'b1;
`endif
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
          state_d = S_PLAY;
`ifdef TOW_TIMEOUT_EN
          timer_d = '0;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are decoded from the next state so they register alongside it.
    play_en_d    = (state_d == S_PLAY);
    round_clr_d  = (state_d != S_PLAY);
    match_over_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      hold_cnt_q   <= '0;
      games1_q     <= '0;
      games2_q     <= '0;
      winner_q     <= 2'b00;
      play_en_q    <= 1'b0;
      round_clr_q  <= 1'b1;
      match_over_q <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef TOW_TIMEOUT_EN
      timer_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      games1_q     <= games1_d;
      games2_q     <= games2_d;
      winner_q     <= winner_d;
      play_en_q    <= play_en_d;
      round_clr_q  <= round_clr_d;
      match_over_q <= match_over_d;
      timeout_q    <= timeout_d;
`ifdef TOW_TIMEOUT_EN
      timer_q      <= timer_d;
`endif
    end
  end

  assign play_en    = play_en_q;
  assign round_clr  = round_clr_q;
  assign games1     = games1_q;
  assign games2     = games2_q;
  assign match_over = match_over_q;
  assign winner     = winner_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_tow_match_ctrl.sv
// Scoreboard bench for tow_match_ctrl: a cycle-level match model predicts every
// output word, a monitor compares each cycle. Honors TOW_TIMEOUT_EN.
module tb_tow_match_ctrl;
  localparam int WINS  = 3;
  localparam int HOLD  = 4;
  localparam int CW    = 4;
  localparam int TMO   = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          win1 = 1'b0;
  logic          win2 = 1'b0;
  logic          play_en, round_clr, match_over, timeout;
  logic [CW-1:0] games1, games2;
  logic [1:0]    winner;

  tow_match_ctrl #(
    .WINS_TO_MATCH(WINS), .HOLD_CYCLES(HOLD), .CNT_W(CW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .win1(win1), .win2(win2),
    .play_en(play_en), .round_clr(round_clr), .games1(games1), .games2(games2),
    .match_over(match_over), .winner(winner), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Expected output word: {play_en, round_clr, games1, games2, match_over, winner, timeout}
  typedef logic [13:0] word_t;
  word_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    stim_done = 0;
  int    cyc = 0;

  // Match model: phase 0=waiting,1=round live,2=cool-down,3=match decided
  int m_phase = 0, m_g1 = 0, m_g2 = 0, m_who = 0, m_left = 0, m_age = 0;

  function automatic word_t model_step(bit rst, bit st, bit w1, bit w2);
    bit to = 0;
    if (rst) begin
      m_phase = 0; m_g1 = 0; m_g2 = 0; m_who = 0;
    end else begin
      case (m_phase)
        0, 3: if (st) begin
          m_phase = 1; m_g1 = 0; m_g2 = 0; m_who = 0; m_age = 0;
        end
        1: begin
          m_age++;
          if (w1 != w2) begin
            if (w1) m_g1++; else m_g2++;
            if (m_g1 == WINS) begin m_phase = 3; m_who = 1; end
            else if (m_g2 == WINS) begin m_phase = 3; m_who = 2; end
            else begin m_phase = 2; m_left = HOLD; end
          end else if (w1 && w2) begin
            m_phase = 2; m_left = HOLD;
          end
`ifdef TOW_TIMEOUT_EN
          else if (m_age == TMO) begin
            to = 1; m_phase = 2; m_left = HOLD;
          end
`endif
        end
        default: begin
          m_left--;
          if (m_left == 0) begin m_phase = 1; m_age = 0; end
        end
      endcase
    end
    return {m_phase == 1, m_phase != 1, CW'(m_g1), CW'(m_g2), m_phase == 3,
            2'(m_who), to};
  endfunction

  task automatic drive(input bit rst, input bit st, input bit w1, input bit w2);
    @(negedge clk);
    reset = rst; start = st; win1 = w1; win2 = w2;
    exp_q.push_back(model_step(rst, st, w1, w2));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  // Monitor: one comparison per DUT output word
  initial begin
    word_t act, expv;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        act  = {play_en, round_clr, games1, games2, match_over, winner, timeout};
        checks++;
        if (act !== expv) begin
          errors++;
          $display("FAIL outputs cyc=%0d actual play=%b clr=%b g1=%0d g2=%0d over=%b win=%b to=%b required play=%b clr=%b g1=%0d g2=%0d over=%b win=%b to=%b",
                   cyc, act[13], act[12], act[11:8], act[7:4], act[3], act[2:1], act[0],
                   expv[13], expv[12], expv[11:8], expv[7:4], expv[3], expv[2:1], expv[0]);
        end else begin
          $display("ok cyc=%0d out=%h", cyc, act);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog elapsed actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, idle, start
    drive(1, 0, 0, 0); drive(1, 0, 0, 0);
    idle(5);
    drive(0, 1, 0, 0);
    idle(2);
    // Win1, then a spurious win1 and start during cool-down
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0); drive(0, 1, 0, 0); idle(3);
    // Two more win1 rounds to take the match, one held across the PLAY->HOLD edge
    drive(0, 0, 1, 0); drive(0, 0, 1, 0); idle(4);
    drive(0, 0, 1, 0); idle(3);
    drive(0, 1, 0, 0); idle(1);
    // Drawn round
    drive(0, 0, 1, 1); idle(6);
    // games2 to 2, then reset mid-hold
    drive(0, 0, 0, 1); idle(5);
    drive(0, 0, 0, 1); idle(2);
    drive(1, 0, 0, 0); idle(3);
    // Long idle round (timeout when enabled)
    drive(0, 1, 0, 0); idle(TMO + 8);
    // Randomized play
    for (int i = 0; i < 4000; i++) begin
      bit r, s, a, b;
      r = ($urandom_range(0, 499) == 0);
      s = ($urandom_range(0, 15) == 0);
      a = ($urandom_range(0, 9) == 0);
      b = ($urandom_range(0, 9) == 0);
      drive(r, s, a, b);
    end
    idle(3);
    stim_done = 1;
  end

  initial begin
    wait (stim_done);
    @(posedge clk); @(posedge clk); #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
